// File: rtl/rls_pkg.sv
// Shared constants, state encoding and sizing helpers for the RLS iteration sequencer.
// All sample data is Q16.16 fixed point.
package rls_pkg;

    localparam int WIDTH    = 32;
    localparam int SIZE     = 16;
    localparam int COMBSIZE = 4;
    localparam int FRAC     = 16;
    localparam int TIMEOUT  = 1024;
    localparam int CNTW     = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN_K = 3'd1,
        ST_RUN_X = 3'd2,
        ST_RUN_P = 3'd3,
        ST_OUT   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    function automatic int nchunk(input int size, input int combsize);
        return size / combsize;
    endfunction

    // Index width that stays at least one bit wide when there is a single chunk.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NCHUNK = nchunk(SIZE, COMBSIZE);

endpackage

// File: rtl/rls_iter_sequencer_if.sv
// Sequencer-to-datapath bus: held sample plus the start/done handshake for each stage.
// A start is a one-cycle pulse; the matching done is honoured only in a later cycle of that stage.
interface rls_iter_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 16,
    parameter int XW    = 2
);

    logic [WIDTH*SIZE-1:0] a_reg;
    logic [WIDTH-1:0]      b_reg;
    logic                  k_start;
    logic                  k_done;
    logic                  x_start;
    logic                  x_done;
    logic [XW-1:0]         x_chunk;
    logic                  p_start;
    logic                  p_done;

    modport master (
        output a_reg, b_reg, k_start, x_start, x_chunk, p_start,
        input  k_done, x_done, p_done
    );

    modport slave (
        input  a_reg, b_reg, k_start, x_start, x_chunk, p_start,
        output k_done, x_done, p_done
    );

endinterface

// File: rtl/rls_watchdog.sv
// Stage watchdog: cleared when a start is issued, counts every cycle of the stage,
// and flags expiry in the cycle the count would reach TIMEOUT-1.
module rls_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/rls_iter_sequencer.sv
// Sequences one RLS iteration per sample: gain (k), chunked Updatex passes, P update,
// then a valid/ready result handshake. Per-stage watchdog drives a sticky error state.
module rls_iter_sequencer #(
    parameter int WIDTH    = rls_pkg::WIDTH,
    parameter int SIZE     = rls_pkg::SIZE,
    parameter int COMBSIZE = rls_pkg::COMBSIZE,
    parameter int TIMEOUT  = rls_pkg::TIMEOUT,
    parameter int CNTW     = rls_pkg::CNTW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*SIZE-1:0]   a_in,
    input  logic [WIDTH-1:0]        b_in,
    rls_iter_sequencer_if.master    dp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNTW-1:0]         iter_count,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr,
    output rls_pkg::state_t         dbg_state
);

    import rls_pkg::*;

    localparam int NCHUNK = SIZE / COMBSIZE;
    localparam int XW     = rls_pkg::idx_w(NCHUNK);
    localparam logic [XW-1:0] LAST_CHUNK = XW'(NCHUNK - 1);

    state_t state;
    logic   capture;
    logic   k_fire;
    logic   x_fire;
    logic   p_fire;
    logic   wd_clear;
    logic   wd_enable;
    logic   wd_expired;

    // A start register still high marks the start cycle, where a done is not yet honoured.
    assign capture   = (state == ST_IDLE)  && in_valid && in_ready;
    assign k_fire    = (state == ST_RUN_K) && !dp.k_start && dp.k_done;
    assign x_fire    = (state == ST_RUN_X) && !dp.x_start && dp.x_done;
    assign p_fire    = (state == ST_RUN_P) && !dp.p_start && dp.p_done;
    assign wd_clear  = capture || k_fire || x_fire;
    assign wd_enable = (state == ST_RUN_K) || (state == ST_RUN_X) || (state == ST_RUN_P);

    rls_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            iter_count <= '0;
            err        <= 1'b0;
            dp.a_reg   <= '0;
            dp.b_reg   <= '0;
            dp.k_start <= 1'b0;
            dp.x_start <= 1'b0;
            dp.p_start <= 1'b0;
            dp.x_chunk <= '0;
        end else begin
            dp.k_start <= 1'b0;
            dp.x_start <= 1'b0;
            dp.p_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        dp.a_reg   <= a_in;
                        dp.b_reg   <= b_in;
                        dp.k_start <= 1'b1;
                        in_ready   <= 1'b0;
                        state      <= ST_RUN_K;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_RUN_K: begin
                    if (k_fire) begin
                        dp.x_chunk <= '0;
                        dp.x_start <= 1'b1;
                        state      <= ST_RUN_X;
                    end else if (wd_expired) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end
                end
                ST_RUN_X: begin
                    if (x_fire) begin
                        if (dp.x_chunk == LAST_CHUNK) begin
                            dp.p_start <= 1'b1;
                            state      <= ST_RUN_P;
                        end else begin
                            dp.x_chunk <= dp.x_chunk + 1'b1;
                            dp.x_start <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end
                end
                ST_RUN_P: begin
                    if (p_fire) begin
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (wd_expired) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        iter_count <= iter_count + 1'b1;
                        in_ready   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (err_clr) begin
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule
